// File: rtl/div_iter_32_if.sv
// div_iter_32_if -- operand/result bundle for the iterative 32-bit divider.
//
// Handshake: the requester raises ctrl_DIV for one clock together with
// data_operandA/data_operandB; the divider answers with a one-cycle
// data_resultRDY pulse, and data_result/data_remainder/data_exception are
// valid in that cycle and hold until the next operation completes. There is
// no back-pressure: a new ctrl_DIV always wins and aborts any operation in
// flight.
//
// Modports:
//   master : requester side (drives ctrl_DIV and the operands)
//   slave  : divider side   (drives the result, remainder, exception, RDY)
interface div_iter_32_if;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic [31:0] data_remainder;
   logic        data_exception;
   logic        data_resultRDY;

   modport master (
      output ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_remainder, data_exception, data_resultRDY
   );

   modport slave (
      input  ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_remainder, data_exception, data_resultRDY
   );
endinterface

// File: rtl/div_iter_32.sv
// div_iter_32 -- signed 32-bit restoring divider, one quotient bit per clock.
//
// Operands are captured on the edge where ctrl_DIV=1, converted to magnitudes
// and divided over 32 shift/subtract iterations in a 64-bit remainder/quotient
// register. One extra edge applies the signs and registers the outputs, so
// data_resultRDY pulses in the cycle after the 33rd edge following capture.
// A zero divisor short-circuits to completion after one edge.
//
// Ports:
//   clock       : sole clock, rising edge
//   reset_n     : asynchronous active-low reset
//   div_bus     : div_iter_32_if.slave (start strobe, operands, results, RDY)
//   dbg_state_o : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//   dbg_count_o : iteration counter
module div_iter_32 #(
   parameter int WIDTH = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   div_iter_32_if.slave  div_bus,
   output logic [1:0]    dbg_state_o,
   output logic [5:0]    dbg_count_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0] rq_q, rq_d;
   logic [WIDTH-1:0]   abs_b_q, abs_b_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic               div_zero_q, div_zero_d;
   logic               ovf_q, ovf_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               exc_q, exc_d;
   logic               rdy;

   logic               capture;
   logic               iter_done;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] rq_iter;
   logic [WIDTH-1:0]   quot_fin;
   logic [WIDTH-1:0]   rem_fin;

   assign capture   = div_bus.ctrl_DIV;
   // Counter runs 0..31 for the iterations and parks at 32 for the sign fix-up edge.
   assign iter_done = (cnt_q == 6'(WIDTH));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (capture) begin
         // A start strobe always restarts, whatever the current state.
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (div_zero_q || iter_done) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      rdy         = (state_q == S_DONE);
      dbg_state_o = state_q;
      dbg_count_o = cnt_q;
   end

   // ---------------- datapath: combinational ----------------
   always_comb begin
      // -2^31 negates to itself, which read as unsigned is the correct magnitude.
      abs_a = div_bus.data_operandA[WIDTH-1] ? (-div_bus.data_operandA)
                                             : div_bus.data_operandA;

      // Trial subtraction of the divisor from the upper half of (RQ << 1).
      diff    = {1'b0, rq_q[2*WIDTH-2:WIDTH-1]} - {1'b0, abs_b_q};
      rq_iter = diff[WIDTH] ? {rq_q[2*WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b1};

      quot_fin = (sign_a_q ^ sign_b_q) ? (-rq_q[WIDTH-1:0]) : rq_q[WIDTH-1:0];
      rem_fin  = sign_a_q ? (-rq_q[2*WIDTH-1:WIDTH]) : rq_q[2*WIDTH-1:WIDTH];

      rq_d       = rq_q;
      cnt_d      = cnt_q;
      abs_b_d    = abs_b_q;
      op_a_d     = op_a_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      div_zero_d = div_zero_q;
      ovf_d      = ovf_q;
      result_d   = result_q;
      rem_d      = rem_q;
      exc_d      = exc_q;

      if (capture) begin
         rq_d       = {{WIDTH{1'b0}}, abs_a};
         cnt_d      = '0;
         abs_b_d    = div_bus.data_operandB[WIDTH-1] ? (-div_bus.data_operandB)
                                                     : div_bus.data_operandB;
         op_a_d     = div_bus.data_operandA;
         sign_a_d   = div_bus.data_operandA[WIDTH-1];
         sign_b_d   = div_bus.data_operandB[WIDTH-1];
         div_zero_d = (div_bus.data_operandB == '0);
         ovf_d      = (div_bus.data_operandA == MIN_NEG) && (div_bus.data_operandB == '1);
      end else if (state_q == S_RUN) begin
         if (div_zero_q) begin
            result_d = '0;
            rem_d    = op_a_q;
            exc_d    = 1'b1;
         end else if (!iter_done) begin
            rq_d  = rq_iter;
            cnt_d = cnt_q + 6'd1;
         end else begin
            // The -2^31 / -1 quotient wraps back to 0x80000000 through quot_fin.
            result_d = quot_fin;
            rem_d    = rem_fin;
            exc_d    = ovf_q;
         end
      end
   end

   // ---------------- datapath: registers ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rq_q       <= '0;
         cnt_q      <= '0;
         abs_b_q    <= '0;
         op_a_q     <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         result_q   <= '0;
         rem_q      <= '0;
         exc_q      <= 1'b0;
      end else begin
         rq_q       <= rq_d;
         cnt_q      <= cnt_d;
         abs_b_q    <= abs_b_d;
         op_a_q     <= op_a_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         div_zero_q <= div_zero_d;
         ovf_q      <= ovf_d;
         result_q   <= result_d;
         rem_q      <= rem_d;
         exc_q      <= exc_d;
      end
   end

   assign div_bus.data_result    = result_q;
   assign div_bus.data_remainder = rem_q;
   assign div_bus.data_exception = exc_q;
   assign div_bus.data_resultRDY = rdy;

endmodule

// File: doc/div_iter_32.md
DIV_ITER_32 -- requirements
Module: div_iter_32

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; the working register is 2*WIDTH = 64 bits; only 32 is supported.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ctrl_DIV  input  1  start strobe, sampled on the rising edge; one-cycle pulse expected.
REQ-005 data_operandA  input  32  signed dividend, sampled only on the edge where ctrl_DIV=1.
REQ-006 data_operandB  input  32  signed divisor, sampled only on the edge where ctrl_DIV=1.
REQ-007 data_result  output  32  signed quotient, truncated toward zero.
REQ-008 data_remainder  output  32  signed remainder; sign follows the dividend.
REQ-009 data_exception  output  1  divide-by-zero or overflow flag; valid while data_resultRDY=1 and held afterwards.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.

Function
REQ-011 States SHALL be IDLE, RUN, DONE, in a registered FSM with a 6-bit iteration counter.
REQ-012 ctrl_DIV=1 in any state SHALL capture both operands, |A|, |B|, sign flags and the counter (0), and enter RUN next cycle; any operation in flight is aborted without an RDY pulse.
REQ-013 Capture SHALL load the 64-bit register RQ = {32'b0, |A|}; |-2^31| is taken as unsigned 0x80000000.
REQ-014 Each RUN cycle SHALL form S = RQ shifted left by one with bit0=0, then D = S[63:32] - |B| as a 33-bit subtraction.
REQ-015 If D is non-negative, RQ SHALL become {D[31:0], S[31:1], 1'b1}; otherwise RQ SHALL become S.
REQ-016 RUN SHALL perform exactly 32 iterations (counter 0..31), then enter DONE.
REQ-017 Latency: ctrl_DIV sampled at edge E0 -> iterations on E1..E32 -> data_resultRDY=1 for the single cycle after edge E33.
REQ-018 In DONE, data_result SHALL be RQ[31:0], negated if sign(A) != sign(B); data_remainder SHALL be RQ[63:32], negated if A < 0.
REQ-019 DONE SHALL last one cycle, then IDLE; data_result, data_remainder and data_exception SHALL hold until the next capture.
REQ-020 Divisor = 0: the block SHALL skip RUN and enter DONE on E1 (RDY in the cycle after E1), with data_result=0, data_remainder=data_operandA and data_exception=1.
REQ-021 A=0x80000000 with B=0xFFFFFFFF: data_result=0x80000000 (wrapped), data_remainder=0, data_exception=1, with normal 33-edge latency.
REQ-022 All other cases SHALL produce data_exception=0.
REQ-023 ctrl_DIV sampled while in DONE: the RDY pulse of that cycle stands, and the new operation starts as in REQ-012.
REQ-024 ctrl_DIV held high SHALL restart the operation every cycle; no RDY pulse occurs until it is released.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, counter=0, RQ=0, data_result=0, data_remainder=0, data_exception=0 and data_resultRDY=0, regardless of clock.
REQ-026 Reset mid-operation SHALL discard the operation; no RDY pulse follows reset release.
REQ-027 After release, the first rising edge with ctrl_DIV=1 SHALL start normally.

Verification
REQ-028 A=100, B=7 -> after E33: result 14, remainder 2, exception 0, RDY high exactly one cycle.
REQ-029 A=-100 (0xFFFFFF9C), B=7 -> result 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2), exception 0; likewise A=100, B=-7 -> result -14, remainder 2.
REQ-030 A=5, B=0 -> RDY in the cycle after E1, result 0, remainder 5, exception 1.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> after E33: result 0x80000000, remainder 0, exception 1.
REQ-032 Start 100/7, then at counter=10 pulse ctrl_DIV with 9/3 -> no RDY for the first operation; RDY 33 edges after the second start with result 3, remainder 0.
REQ-033 Start 100/7, drive reset_n low at counter=5 -> outputs 0 asynchronously; after release with no ctrl_DIV, RDY stays 0 for 40 cycles.
